// File: rtl/matrix_result_buffer.sv
// Captures the multiplier's matrix C write stream into a DIM x DIM store, then
// streams the completed matrix out row-major over valid/ready before rearming.
module matrix_result_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 10,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en_WriteMat_C,
  input  logic [ADDR_WIDTH-1:0] rowAddr_C,
  input  logic [ADDR_WIDTH-1:0] colAddr_C,
  input  logic [DATA_WIDTH-1:0] writeData_C,
  input  logic                  resultIsInvalid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_row,
  output logic [ADDR_WIDTH-1:0] out_col,
  output logic                  out_invalid,
  output logic                  out_last,
  output logic [6:0]            fill_count,
  output logic                  addr_err,
  output logic                  overflow_err,
  input  logic                  clr_err
);

  localparam int TOTAL = DIM * DIM;
  localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(TOTAL - 1);
  localparam logic [IDX_W-1:0]    IDX_DIM   = IDX_W'(DIM);
  localparam logic [ADDR_WIDTH-1:0] DIM_M1  = ADDR_WIDTH'(DIM - 1);
  localparam logic [ADDR_WIDTH:0] DIM_CMP   = (ADDR_WIDTH + 1)'(DIM);
  localparam logic [6:0]          FILL_FULL = 7'(TOTAL);
  localparam logic [6:0]          FILL_LAST = 7'(TOTAL - 1);

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [DATA_WIDTH-1:0]   r_mem [TOTAL];
  logic [TOTAL-1:0]        r_inv;
  logic [TOTAL-1:0]        r_written;
  logic [6:0]              r_fill_count;
  logic [ADDR_WIDTH-1:0]   r_rd_row;
  logic [ADDR_WIDTH-1:0]   r_rd_col;
  logic [IDX_W-1:0]        r_rd_idx;
  logic                    r_addr_err;
  logic                    r_ovf_err;

  logic                    w_in_range;
  logic [IDX_W-1:0]        w_wr_idx;
  logic                    w_wr_acc;
  logic                    w_wr_new;
  logic                    w_addr_ev;
  logic                    w_ovf_ev;
  logic                    w_at_last;
  logic                    w_hs;
  logic                    w_out_valid;
  logic                    w_out_last;

  // Address widened by one bit so DIM == 2**ADDR_WIDTH still compares correctly
  assign w_in_range = ({1'b0, rowAddr_C} < DIM_CMP) && ({1'b0, colAddr_C} < DIM_CMP);
  assign w_wr_idx   = IDX_W'(rowAddr_C) * IDX_DIM + IDX_W'(colAddr_C);
  assign w_wr_acc   = (r_state == S_FILL) && en_WriteMat_C && w_in_range;
  assign w_wr_new   = w_wr_acc && !r_written[w_wr_idx];
  assign w_addr_ev  = (r_state == S_FILL) && en_WriteMat_C && !w_in_range;
  assign w_ovf_ev   = (r_state == S_DRAIN) && en_WriteMat_C;
  assign w_at_last  = (r_rd_idx == LAST_IDX);
  assign w_hs       = w_out_valid && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FILL: begin
        if (w_wr_new && (r_fill_count == FILL_LAST)) begin
          w_next_state = S_DRAIN;
        end else begin
          w_next_state = S_FILL;
        end
      end
      S_DRAIN: begin
        if (w_hs && w_at_last) begin
          w_next_state = S_FILL;
        end else begin
          w_next_state = S_DRAIN;
        end
      end
      default: w_next_state = S_FILL;
    endcase
  end

  // Stream control outputs
  always_comb begin
    w_out_valid = 1'b0;
    w_out_last  = 1'b0;
    case (r_state)
      S_FILL: begin
        w_out_valid = 1'b0;
        w_out_last  = 1'b0;
      end
      S_DRAIN: begin
        w_out_valid = 1'b1;
        w_out_last  = w_at_last;
      end
      default: begin
        w_out_valid = 1'b0;
        w_out_last  = 1'b0;
      end
    endcase
  end

  // Element store; contents survive a drain and are only replaced by new writes
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < TOTAL; i++) begin
        r_mem[i] <= '0;
      end
      r_inv <= '0;
    end else if (w_wr_acc) begin
      r_mem[w_wr_idx] <= writeData_C;
      r_inv[w_wr_idx] <= resultIsInvalid;
    end
  end

  // Written bitmap and distinct-element count
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_written    <= '0;
      r_fill_count <= 7'd0;
    end else if (w_hs && w_at_last) begin
      r_written    <= '0;
      r_fill_count <= 7'd0;
    end else if (w_wr_new) begin
      r_written[w_wr_idx] <= 1'b1;
      if (r_fill_count != FILL_FULL) begin
        r_fill_count <= r_fill_count + 7'd1;
      end
    end
  end

  // Read index, advanced column-first on each accepted beat
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_row <= '0;
      r_rd_col <= '0;
      r_rd_idx <= '0;
    end else if (w_hs) begin
      if (w_at_last) begin
        r_rd_row <= '0;
        r_rd_col <= '0;
        r_rd_idx <= '0;
      end else begin
        if (r_rd_col == DIM_M1) begin
          r_rd_col <= '0;
          r_rd_row <= r_rd_row + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          r_rd_col <= r_rd_col + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
        r_rd_idx <= r_rd_idx + {{(IDX_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Sticky error flags; a new error event outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr_err <= 1'b0;
      r_ovf_err  <= 1'b0;
    end else begin
      if (w_addr_ev) begin
        r_addr_err <= 1'b1;
      end else if (clr_err) begin
        r_addr_err <= 1'b0;
      end
      if (w_ovf_ev) begin
        r_ovf_err <= 1'b1;
      end else if (clr_err) begin
        r_ovf_err <= 1'b0;
      end
    end
  end

  assign out_valid    = w_out_valid;
  assign out_last     = w_out_last;
  assign out_row      = r_rd_row;
  assign out_col      = r_rd_col;
  assign out_data     = r_mem[r_rd_idx];
  assign out_invalid  = r_inv[r_rd_idx];
  assign fill_count   = r_fill_count;
  assign addr_err     = r_addr_err;
  assign overflow_err = r_ovf_err;

endmodule
